// File: rtl/npc_multicycle_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and memories.
// Latency: none, wires only.
// Backpressure: req_valid is held by the master until the slave raises req_ready.
interface npc_multicycle_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output dmem_req_valid,
        input  dmem_req_ready,
        input  dmem_rsp_valid
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  dmem_req_valid,
        output dmem_req_ready,
        input  dmem_rsp_valid
    );
endinterface

// File: rtl/npc_multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC core.
// Latency: 5 cycles per ALU instruction, 7 per load/store with zero-wait memory.
// Backpressure: requests hold until ready; waits for a response time out into a sticky error.
module npc_multicycle_ctrl #(
    parameter int         TIMEOUT   = 255,
    parameter logic [2:0] RST_STATE = 3'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    npc_multicycle_ctrl_if.master     mem,
    output logic [31:0]               inst,
    input  logic                      regwr_dec,
    output logic                      regwr_en,
    output logic                      pc_we,
    output logic                      halt,
    output logic                      err,
    output logic [31:0]               instret
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [7:0]  TMO       = 8'(TIMEOUT);

    // FETCH takes the reset encoding; the rest follow it consecutively.
    typedef enum logic [3:0] {
        FETCH = 4'(RST_STATE),
        IWAIT,
        DECODE,
        EXEC,
        MEM,
        MWAIT,
        WB,
        HALT,
        ERR
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] tmo_cnt, tmo_cnt_nxt;
    logic       inst_ld;
    logic       retire;

    // State, instruction register, timeout counter and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            inst    <= NOP;
            tmo_cnt <= '0;
            instret <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (inst_ld) inst    <= mem.imem_rsp_data;
            if (retire)  instret <= instret + 32'd1;
        end
    end

    // Next-state logic; the counter is zero outside the wait states, so every wait entry starts from zero.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = '0;
        inst_ld     = 1'b0;
        case (state)
            FETCH:  if (mem.imem_req_ready) state_nxt = IWAIT;
            IWAIT: begin
                if (mem.imem_rsp_valid) begin
                    inst_ld   = 1'b1;
                    state_nxt = DECODE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                    if (tmo_cnt_nxt == TMO) state_nxt = ERR;
                end
            end
            DECODE: state_nxt = (inst[6:0] == OP_SYSTEM) ? HALT : EXEC;
            EXEC:   state_nxt = (inst[6:0] == OP_LOAD || inst[6:0] == OP_STORE) ? MEM : WB;
            MEM:    if (mem.dmem_req_ready) state_nxt = MWAIT;
            MWAIT: begin
                if (mem.dmem_rsp_valid) begin
                    state_nxt = WB;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                    if (tmo_cnt_nxt == TMO) state_nxt = ERR;
                end
            end
            WB:     state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            ERR:    state_nxt = ERR;
            default: state_nxt = FETCH;
        endcase
    end

    // Moore outputs; pulses and requests are forced low while reset is held.
    always_comb begin
        mem.imem_req_valid = (state == FETCH) && !rst;
        mem.dmem_req_valid = (state == MEM) && !rst;
        retire             = (state == WB);
        pc_we              = retire && !rst;
        regwr_en           = pc_we && regwr_dec && (inst[6:0] != OP_STORE) && (inst[11:7] != 5'd0);
        halt               = (state == HALT);
        err                = (state == ERR);
    end

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
// Scoreboard bench for npc_multicycle_ctrl: stimulus queues expected writebacks, a monitor checks them.
// Latency: expected writeback cycles are computed from the fetch-accept cycle.
// Backpressure: dmem ready is stalled by directed amounts; imem responses are withheld for timeout.
module tb_npc_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        regwr_dec;
    logic        regwr_en;
    logic        pc_we;
    logic        halt;
    logic        err;
    logic [31:0] instret;

    npc_multicycle_ctrl_if mif();

    npc_multicycle_ctrl #(.TIMEOUT(255), .RST_STATE(3'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mif),
        .inst      (inst),
        .regwr_dec (regwr_dec),
        .regwr_en  (regwr_en),
        .pc_we     (pc_we),
        .halt      (halt),
        .err       (err),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [31:0] ins;
        logic [31:0] ir;
        int          wb;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_ir = 0;
    int          exp_next = 0;
    bit          have_next = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback pulse is matched against the oldest expected retirement.
    always @(negedge clk) begin
        if (!rst) begin
            if (pc_we === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_pc_we", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("wb_cycle", cyc, mon_e.wb);
                    check("wb_regwr_en", {31'd0, regwr_en}, {31'd0, mon_e.rw});
                    check("wb_inst", inst, mon_e.ins);
                    check("wb_instret", instret, mon_e.ir);
                end
            end else if (regwr_en === 1'b1) begin
                check("stray_regwr_en", 32'd1, 32'd0);
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        exp_ir = 0;
        have_next = 0;
        #1;
    endtask

    // Runs one instruction with zero-wait imem and a dmem accept stall of 'stall' cycles.
    task automatic do_inst(input logic [31:0] ins, input logic rd, input bit is_mem,
                           input int stall, input logic exp_rw);
        int c;
        for (int i = 0; i < 20 && mif.imem_req_valid !== 1'b1; i++) @(negedge clk);
        check("fetch_req_valid", {31'd0, mif.imem_req_valid}, 32'd1);
        c = cyc;
        if (have_next) check("fetch_start_cycle", c, exp_next);
        q.push_back('{exp_rw, ins, exp_ir, c + (is_mem ? 6 + stall : 4)});
        exp_ir = exp_ir + 1;
        regwr_dec = rd;
        mif.imem_req_ready = 1'b1;
        @(negedge clk);
        mif.imem_req_ready = 1'b0;
        mif.imem_rsp_valid = 1'b1;
        mif.imem_rsp_data  = ins;
        @(negedge clk);
        mif.imem_rsp_valid = 1'b0;
        mif.imem_rsp_data  = '0;
        @(negedge clk);
        if (is_mem) begin
            @(negedge clk);
            for (int k = 0; k <= stall; k++) begin
                check("dmem_req_valid_held", {31'd0, mif.dmem_req_valid}, 32'd1);
                mif.dmem_req_ready = (k == stall);
                @(negedge clk);
            end
            check("dmem_req_dropped", {31'd0, mif.dmem_req_valid}, 32'd0);
            mif.dmem_req_ready = 1'b0;
            mif.dmem_rsp_valid = 1'b1;
            @(negedge clk);
            mif.dmem_rsp_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
        exp_next  = c + (is_mem ? 7 + stall : 5);
        have_next = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        regwr_dec = 1'b0;
        mif.imem_req_ready = 1'b0;
        mif.imem_rsp_valid = 1'b0;
        mif.imem_rsp_data  = '0;
        mif.dmem_req_ready = 1'b0;
        mif.dmem_rsp_valid = 1'b0;

        // Reset for two cycles; requests must stay low while rst is held.
        @(negedge clk);
        check("rst_imem_req", {31'd0, mif.imem_req_valid}, 32'd0);
        @(negedge clk);
        check("rst_imem_req2", {31'd0, mif.imem_req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_imem_req", {31'd0, mif.imem_req_valid}, 32'd1);
        check("post_rst_inst", inst, 32'h0000_0013);
        check("post_rst_instret", instret, 32'd0);
        check("post_rst_halt", {31'd0, halt}, 32'd0);
        check("post_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);

        // Instruction mix: ALU, stalled load, store, rd=x0, R-type.
        do_inst(32'h0010_0093, 1'b1, 1'b0, 0, 1'b1);
        do_inst(32'h0000_a103, 1'b1, 1'b1, 3, 1'b1);
        do_inst(32'h0020_a023, 1'b1, 1'b1, 0, 1'b0);
        do_inst(32'h0000_0013, 1'b1, 1'b0, 0, 1'b0);
        do_inst(32'h0020_81b3, 1'b1, 1'b0, 0, 1'b1);
        do_inst(32'h0020_81b3, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("instret_after_mix", instret, exp_ir);

        // ebreak: HALT two cycles after the response, no writeback.
        check("halt_fetch_req", {31'd0, mif.imem_req_valid}, 32'd1);
        regwr_dec = 1'b1;
        mif.imem_req_ready = 1'b1;
        @(negedge clk);
        mif.imem_req_ready = 1'b0;
        mif.imem_rsp_valid = 1'b1;
        mif.imem_rsp_data  = 32'h0010_0073;
        @(negedge clk);
        mif.imem_rsp_valid = 1'b0;
        check("halt_in_decode", {31'd0, halt}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("halt_sticky", {31'd0, halt}, 32'd1);
            check("halt_no_imem_req", {31'd0, mif.imem_req_valid}, 32'd0);
            check("halt_instret", instret, exp_ir);
            mif.imem_req_ready = 1'b1;
            @(negedge clk);
        end
        mif.imem_req_ready = 1'b0;
        do_reset(1);
        check("halt_cleared", {31'd0, halt}, 32'd0);
        check("halt_rst_instret", instret, 32'd0);
        check("halt_rst_fetch", {31'd0, mif.imem_req_valid}, 32'd1);

        // Instruction timeout: 255 IWAIT cycles without a response.
        mif.imem_req_ready = 1'b1;
        @(negedge clk);
        mif.imem_req_ready = 1'b0;
        repeat (254) @(negedge clk);
        check("err_before_timeout", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("err_at_timeout", {31'd0, err}, 32'd1);
        mif.imem_rsp_valid = 1'b1;
        mif.dmem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("err_no_imem_req", {31'd0, mif.imem_req_valid}, 32'd0);
            check("err_no_dmem_req", {31'd0, mif.dmem_req_valid}, 32'd0);
            @(negedge clk);
        end
        check("err_sticky", {31'd0, err}, 32'd1);
        mif.imem_rsp_valid = 1'b0;
        mif.dmem_req_ready = 1'b0;
        do_reset(1);
        check("err_cleared", {31'd0, err}, 32'd0);

        // One retirement, then reset during MWAIT with a late dmem response.
        do_inst(32'h0010_0093, 1'b1, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("pre_abort_instret", instret, 32'd1);
        mif.imem_req_ready = 1'b1;
        @(negedge clk);
        mif.imem_req_ready = 1'b0;
        mif.imem_rsp_valid = 1'b1;
        mif.imem_rsp_data  = 32'h0000_a103;
        @(negedge clk);
        mif.imem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_mem_req", {31'd0, mif.dmem_req_valid}, 32'd1);
        mif.dmem_req_ready = 1'b1;
        @(negedge clk);
        mif.dmem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ir = 0;
        have_next = 0;
        mif.dmem_rsp_valid = 1'b1;
        mif.imem_rsp_valid = 1'b1;
        mif.imem_rsp_data  = 32'hdead_beef;
        #1;
        check("abort_fetch", {31'd0, mif.imem_req_valid}, 32'd1);
        check("abort_pc_we", {31'd0, pc_we}, 32'd0);
        check("abort_regwr_en", {31'd0, regwr_en}, 32'd0);
        check("abort_instret", instret, 32'd0);
        @(negedge clk);
        mif.dmem_rsp_valid = 1'b0;
        mif.imem_rsp_valid = 1'b0;
        check("abort_still_fetch", {31'd0, mif.imem_req_valid}, 32'd1);
        check("abort_inst_kept", inst, 32'h0000_0013);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
